bsg_manycore_load_sequencer: RTL and testbench



---
 rtl/bsg_manycore_loader_pkg.sv | 35 +++
 rtl/bsg_manycore_next_tile_finder.sv | 30 +++
 rtl/bsg_manycore_load_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_bsg_manycore_load_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_loader_pkg.sv
// Shared definitions for the manycore program loader.
//   - packet opcodes (store, unfreeze)
//   - loader FSM state encoding
//   - packet layout {op, addr, data, y, x} for the default array geometry
//     (4x4 array, 20-bit address, 32-bit data). Modules with other geometries
//     declare the same field order with their own widths.
package bsg_manycore_loader_pkg;

  localparam int op_width_lp = 6;

  localparam logic [op_width_lp-1:0] opcode_store_lp    = 6'd1;
  localparam logic [op_width_lp-1:0] opcode_unfreeze_lp = 6'd2;

  typedef enum logic [2:0] {
    e_idle     = 3'd0,
    e_load     = 3'd1,
    e_drain    = 3'd2,
    e_unfreeze = 3'd3,
    e_done     = 3'd4
  } load_state_e;

  localparam int default_addr_width_lp = 20;
  localparam int default_data_width_lp = 32;
  localparam int default_y_width_lp    = 3;
  localparam int default_x_width_lp    = 2;

  typedef struct packed {
    logic [op_width_lp-1:0]           op;
    logic [default_addr_width_lp-1:0] addr;
    logic [default_data_width_lp-1:0] data;
    logic [default_y_width_lp-1:0]    y;
    logic [default_x_width_lp-1:0]    x;
  } load_packet_s;

endpackage

// File: rtl/bsg_manycore_next_tile_finder.sv
// Combinational priority encoder over the tile enable mask.
// Returns the lowest set mask bit whose index is >= from_i.
// Ports:
//   mask_i   in  num_tiles_p      tile enable mask
//   from_i   in  tile_width_lp+1  first index to consider (may equal num_tiles_p)
//   tile_o   out tile_width_lp    index of the found tile (0 when none)
//   found_o  out 1                a set bit exists at or above from_i
module bsg_manycore_next_tile_finder #(
  parameter int num_tiles_p = 16,
  localparam int tile_width_lp = (num_tiles_p > 1) ? $clog2(num_tiles_p) : 1
) (
  input  logic [num_tiles_p-1:0]   mask_i,
  input  logic [tile_width_lp:0]   from_i,
  output logic [tile_width_lp-1:0] tile_o,
  output logic                     found_o
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    found_o = 1'b0;
    tile_o  = '0;
    for (int i = num_tiles_p - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(from_i))) begin
        found_o = 1'b1;
        tile_o  = tile_width_lp'(i);
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_load_sequencer.sv
// Program-load sequencer for a manycore array. Streams a word-addressed image
// to every enabled tile as store packets (patching the tile ID word), throttled
// by an outstanding-credit counter, waits for all credits, then unfreezes each
// enabled tile.
// Ports:
//   clk_i            in  1                clock
//   reset_n_i        in  1                asynchronous active-low reset
//   start_i          in  1                start a load (honoured in IDLE/DONE)
//   tile_mask_i      in  rows*cols        per-tile enable, sampled at start
//   mem_addr_o       out addr_width_p     image word index (byte addr >> 2)
//   mem_data_i       in  data_width_p     combinational image read data
//   pkt_o            out packet_width_lp  {op, addr, data, y, x}
//   v_o              out 1                packet valid
//   ready_i          in  1                network accepts packet
//   credit_return_i  in  1                one store acknowledged
//   busy_o           out 1                LOAD, DRAIN or UNFREEZE
//   done_o           out 1                DONE
// Build option: BSG_MANYCORE_LOAD_SEQUENCER_SKIP_ZERO_EN skips all-zero image
// words (other than the tile ID word) during LOAD.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | streaming image words to the current tile
// DRAIN    | waiting for every outstanding store to be acknowledged
// UNFREEZE | sending one unfreeze packet per enabled tile
// DONE     | load complete, waiting for the next start
module bsg_manycore_load_sequencer
  import bsg_manycore_loader_pkg::*;
#(
  parameter int mem_size_p        = 4096,
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 20,
  parameter int tile_id_ptr_p     = 0,
  parameter int num_rows_p        = 4,
  parameter int num_cols_p        = 4,
  parameter int max_out_credits_p = 16,
  localparam int y_cord_width_lp  = $clog2(num_rows_p + 1),
  localparam int x_cord_width_lp  = $clog2(num_cols_p),
  localparam int packet_width_lp  = 6 + addr_width_p + data_width_p + y_cord_width_lp + x_cord_width_lp
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             start_i,
  input  logic [num_rows_p*num_cols_p-1:0] tile_mask_i,
  output logic [addr_width_p-1:0]          mem_addr_o,
  input  logic [data_width_p-1:0]          mem_data_i,
  output logic [packet_width_lp-1:0]       pkt_o,
  output logic                             v_o,
  input  logic                             ready_i,
  input  logic                             credit_return_i,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int num_tiles_lp    = num_rows_p * num_cols_p;
  localparam int tile_width_lp   = (num_tiles_lp > 1) ? $clog2(num_tiles_lp) : 1;
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1);

  localparam logic [addr_width_p-1:0]    last_addr_lp   = addr_width_p'(mem_size_p - 4);
  localparam logic [addr_width_p-1:0]    id_addr_lp     = addr_width_p'(tile_id_ptr_p);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  typedef struct packed {
    logic [op_width_lp-1:0]     op;
    logic [addr_width_p-1:0]    addr;
    logic [data_width_p-1:0]    data;
    logic [y_cord_width_lp-1:0] y;
    logic [x_cord_width_lp-1:0] x;
  } packet_s;

  load_state_e                state_q, state_d;
  logic [num_tiles_lp-1:0]    mask_q, mask_d;
  logic [tile_width_lp-1:0]   tile_q, tile_d;
  logic [addr_width_p-1:0]    addr_q, addr_d;
  logic [credit_width_lp-1:0] credits_q, credits_d;

  logic [num_tiles_lp-1:0]    find_mask;
  logic [tile_width_lp:0]     find_from;
  logic [tile_width_lp-1:0]   find_tile;
  logic                       find_found;

  logic                       id_hit, skip_word, hs, load_adv, credit_inc, credit_dec;
  packet_s                    pkt;

  // Start and the DRAIN->UNFREEZE turn search from index 0; everything else
  // looks for the next enabled tile above the current one.
  always_comb begin
    find_mask = mask_q;
    find_from = {1'b0, tile_q} + (tile_width_lp+1)'(1);
    case (state_q)
      e_idle, e_done: begin
        find_mask = tile_mask_i;
        find_from = '0;
      end
      e_drain: find_from = '0;
      default: ;
    endcase
  end

  bsg_manycore_next_tile_finder #(
    .num_tiles_p(num_tiles_lp)
  ) finder (
    .mask_i (find_mask),
    .from_i (find_from),
    .tile_o (find_tile),
    .found_o(find_found)
  );

  assign id_hit = (addr_q == id_addr_lp);

`ifdef BSG_MANYCORE_LOAD_SEQUENCER_SKIP_ZERO_EN
  assign skip_word = (state_q == e_load) && (mem_data_i == '0) && !id_hit;
`else
  assign skip_word = 1'b0;
`endif

  always_comb begin
    v_o = 1'b0;
    case (state_q)
      e_load:     v_o = (credits_q < max_credits_lp) && !skip_word;
      e_unfreeze: v_o = 1'b1;
      default:    v_o = 1'b0;
    endcase
  end

  assign hs       = v_o & ready_i;
  assign load_adv = (state_q == e_load) && (hs || skip_word);

  always_comb begin
    pkt.op   = '0;
    pkt.addr = '0;
    pkt.data = '0;
    pkt.y    = y_cord_width_lp'(int'(tile_q) / num_cols_p);
    pkt.x    = x_cord_width_lp'(int'(tile_q) % num_cols_p);
    if (state_q == e_load) begin
      pkt.op   = opcode_store_lp;
      pkt.addr = addr_q;
      pkt.data = id_hit ? data_width_p'(tile_q) : mem_data_i;
    end else if (state_q == e_unfreeze) begin
      pkt.op = opcode_unfreeze_lp;
    end
  end

  assign pkt_o      = pkt;
  assign mem_addr_o = addr_q >> 2;
  assign busy_o     = (state_q == e_load) || (state_q == e_drain) || (state_q == e_unfreeze);
  assign done_o     = (state_q == e_done);

  // A return with nothing outstanding is dropped rather than wrapping.
  assign credit_inc = hs && (state_q == e_load);
  assign credit_dec = credit_return_i && (credits_q != '0);

  always_comb begin
    credits_d = credits_q;
    case ({credit_inc, credit_dec})
      2'b10:   credits_d = credits_q + credit_width_lp'(1);
      2'b01:   credits_d = credits_q - credit_width_lp'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tile_d  = tile_q;
    addr_d  = addr_q;
    case (state_q)
      e_idle, e_done: begin
        if (start_i) begin
          mask_d  = tile_mask_i;
          addr_d  = '0;
          tile_d  = find_tile;
          state_d = find_found ? e_load : e_done;
        end
      end
      e_load: begin
        if (load_adv) begin
          if (addr_q == last_addr_lp) begin
            addr_d = '0;
            if (find_found) tile_d = find_tile;
            else            state_d = e_drain;
          end else begin
            addr_d = addr_q + addr_width_p'(4);
          end
        end
      end
      e_drain: begin
        // Using the next count lets a final return in this cycle end the drain.
        if (credits_d == '0) begin
          tile_d  = find_tile;
          state_d = e_unfreeze;
        end
      end
      e_unfreeze: begin
        if (hs) begin
          if (find_found) tile_d = find_tile;
          else            state_d = e_done;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= e_idle;
      mask_q    <= '0;
      tile_q    <= '0;
      addr_q    <= '0;
      credits_q <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      tile_q    <= tile_d;
      addr_q    <= addr_d;
      credits_q <= credits_d;
    end
  end

  credit_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(credit_return_i && (credits_q == '0)))
    else $error("credit returned with no stores outstanding");

endmodule

// File: tb/tb_bsg_manycore_load_sequencer.sv
module tb_bsg_manycore_load_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_n_i, start_i, ready_i, credit_return_i;
  logic [3:0]  tile_mask_i;
  logic [19:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic [60:0] pkt_o;
  logic        v_o, busy_o, done_o;

  always #5 clk_i = ~clk_i;

  logic [31:0] rom [4];
  assign mem_data_i = rom[mem_addr_o[1:0]];

  bsg_manycore_load_sequencer #(
    .mem_size_p(16), .data_width_p(32), .addr_width_p(20), .tile_id_ptr_p(0),
    .num_rows_p(2), .num_cols_p(2), .max_out_credits_p(2)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .tile_mask_i(tile_mask_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .pkt_o(pkt_o), .v_o(v_o),
    .ready_i(ready_i), .credit_return_i(credit_return_i), .busy_o(busy_o), .done_o(done_o)
  );

`ifdef BSG_MANYCORE_LOAD_SEQUENCER_SKIP_ZERO_EN
  localparam int sparse_words_lp = 3;
`else
  localparam int sparse_words_lp = 4;
`endif

  typedef struct {
    logic [3:0] mask;
    bit         toggle;
    bit         sparse;
    int         n_store;
    int         n_unf;
  } run_t;

  int          errors = 0;
  int          checks = 0;
  logic [60:0] cap[$];
  logic [60:0] exp_q[$];
  bit          pend = 1'b0;
  bit          hold_v = 1'b0;
  logic [60:0] hold_pkt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [60:0] mk(input logic [5:0] op, input logic [19:0] a,
                                     input logic [31:0] d, input int t);
    logic [1:0] y;
    logic       x;
    y = 2'(t / 2);
    x = 1'(t % 2);
    return {op, a, d, y, x};
  endfunction

  function automatic void set_rom(input bit sparse);
    for (int w = 0; w < 4; w++) rom[w] = 32'hD000_0000 | 32'(w);
    if (sparse) begin
      rom[0] = 32'd0; rom[1] = 32'd5; rom[2] = 32'd0; rom[3] = 32'd7;
    end
  endfunction

  function automatic void build_exp(input logic [3:0] mask);
    exp_q.delete();
    for (int t = 0; t < 4; t++) begin
      if (mask[t]) begin
        for (int w = 0; w < 4; w++) begin
`ifdef BSG_MANYCORE_LOAD_SEQUENCER_SKIP_ZERO_EN
          if (w != 0 && rom[w] == 32'd0) continue;
`endif
          exp_q.push_back(mk(6'd1, 20'(4 * w), (w == 0) ? 32'(t) : rom[w], t));
        end
      end
    end
    for (int t = 0; t < 4; t++)
      if (mask[t]) exp_q.push_back(mk(6'd2, 20'd0, 32'd0, t));
  endfunction

  // One clock: drive inputs at the falling edge, sample 1ns later.
  task automatic step(input logic st, input logic rdy, input logic ret);
    @(negedge clk_i);
    start_i = st;
    ready_i = rdy;
    credit_return_i = ret;
    #1;
    if (hold_v) check("stall pkt hold", 64'(pkt_o), 64'(hold_pkt));
    hold_v   = v_o && !ready_i;
    hold_pkt = pkt_o;
    if (v_o && ready_i) cap.push_back(pkt_o);
    pend = v_o && ready_i && (pkt_o[60:55] == 6'd1);
  endtask

  task automatic compare(input string name);
    int n;
    check($sformatf("%s pkt count", name), 64'(cap.size()), 64'(exp_q.size()));
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s pkt%0d", name, i), 64'(cap[i]), 64'(exp_q[i]));
  endtask

  task automatic wait_done(input string name, input bit toggle);
    int n;
    n = 0;
    while (!done_o && n < 300) begin
      step(1'b0, toggle ? n[0] : 1'b1, pend);
      n++;
    end
    check($sformatf("%s done_o", name), 64'(done_o), 64'd1);
    check($sformatf("%s busy_o at done", name), 64'(busy_o), 64'd0);
  endtask

  task automatic run_load(input run_t r, input string name);
    int ns, nu;
    set_rom(r.sparse);
    tile_mask_i = r.mask;
    cap.delete();
    hold_v = 1'b0;
    build_exp(r.mask);
    step(1'b1, 1'b1, pend);
    step(1'b0, r.toggle ? 1'b0 : 1'b1, pend);
    check($sformatf("%s busy after start", name), 64'(busy_o), 64'(r.mask != 4'd0));
    check($sformatf("%s done after start", name), 64'(done_o), 64'(r.mask == 4'd0));
    wait_done(name, r.toggle);
    ns = 0; nu = 0;
    foreach (cap[i]) begin
      if (cap[i][60:55] == 6'd1) ns++;
      if (cap[i][60:55] == 6'd2) nu++;
    end
    check($sformatf("%s store count", name), 64'(ns), 64'(r.n_store));
    check($sformatf("%s unfreeze count", name), 64'(nu), 64'(r.n_unf));
    compare(name);
  endtask

  initial begin
    run_t runs[5];
    run_t fresh;
    bit   exp_v[16];
    bit   ret_v[16];

    runs[0] = '{mask: 4'b1111, toggle: 1'b0, sparse: 1'b0, n_store: 16, n_unf: 4};
    runs[1] = '{mask: 4'b1010, toggle: 1'b0, sparse: 1'b0, n_store: 8,  n_unf: 2};
    runs[2] = '{mask: 4'b1111, toggle: 1'b1, sparse: 1'b0, n_store: 16, n_unf: 4};
    runs[3] = '{mask: 4'b0000, toggle: 1'b0, sparse: 1'b0, n_store: 0,  n_unf: 0};
    runs[4] = '{mask: 4'b0110, toggle: 1'b1, sparse: 1'b1, n_store: 2 * sparse_words_lp, n_unf: 2};

    exp_v = '{1,1,0,0,0,1,0,0,1,1,0,0,1,1,1,0};
    ret_v = '{0,0,0,0,1,0,0,1,1,0,0,1,1,1,1,1};

    reset_n_i = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b1;
    credit_return_i = 1'b0;
    tile_mask_i = 4'd0;
    set_rom(1'b0);

    repeat (2) @(negedge clk_i);
    #1;
    check("reset v_o", 64'(v_o), 64'd0);
    check("reset busy_o", 64'(busy_o), 64'd0);
    check("reset done_o", 64'(done_o), 64'd0);
    check("reset mem_addr_o", 64'(mem_addr_o), 64'd0);
    reset_n_i = 1'b1;

    for (int i = 0; i < 5; i++) run_load(runs[i], $sformatf("run%0d", i));

    // Credit throttling with max 2 outstanding, manual returns.
    set_rom(1'b0);
    tile_mask_i = 4'b0011;
    cap.delete();
    hold_v = 1'b0;
    build_exp(4'b0011);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, ret_v[i]);
      check($sformatf("credit v_o step%0d", i + 1), 64'(v_o), 64'(exp_v[i]));
    end
    wait_done("credit", 1'b0);
    compare("credit");

    // Reset in the middle of LOAD, then a fresh load from tile 0.
    set_rom(1'b0);
    tile_mask_i = 4'b1111;
    cap.delete();
    step(1'b1, 1'b1, pend);
    repeat (5) step(1'b0, 1'b1, pend);
    check("pre-reset busy_o", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    reset_n_i = 1'b0;
    credit_return_i = 1'b0;
    #1;
    check("mid-load reset v_o", 64'(v_o), 64'd0);
    check("mid-load reset busy_o", 64'(busy_o), 64'd0);
    pend = 1'b0;
    hold_v = 1'b0;
    @(negedge clk_i);
    #1;
    check("post-reset done_o", 64'(done_o), 64'd0);
    check("post-reset mem_addr_o", 64'(mem_addr_o), 64'd0);
    reset_n_i = 1'b1;
    fresh = '{mask: 4'b1111, toggle: 1'b0, sparse: 1'b0, n_store: 16, n_unf: 4};
    run_load(fresh, "after-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
